ex_stage_alu_reg: RTL and testbench
===================================

Name: ex_stage_alu_reg

Overview:
Execute stage of the 5-stage MIPS pipeline, directly downstream of the ALU control decoder. Consumes the 4-bit ALU control code and the ID/EX operands. Resolves operand forwarding, computes the ALU result and flags, and registers everything into the EX/MEM pipeline register. Stall and flush handshakes come from the hazard unit.

Parameters:
DATA_W, 32, datapath width (result, operands, immediate)
REG_AW, 5, register-file address width

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
alu_ctrl  in  4  code from ALU control decoder: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR; any other value is illegal
id_ex_valid  in  1  ID/EX slot holds a real instruction
rs_data  in  DATA_W  register-file operand A
rt_data  in  DATA_W  register-file operand B
imm_ext  in  DATA_W  sign-extended immediate
alu_src  in  1  1: operand B = imm_ext
fwd_a  in  2  operand A select: 00 reg, 10 EX/MEM, 01 MEM/WB, 11 EX/MEM
fwd_b  in  2  operand B select, same encoding
ex_mem_fwd  in  DATA_W  forwarded EX/MEM result
mem_wb_fwd  in  DATA_W  forwarded MEM/WB result
rd_in  in  REG_AW  destination register
reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, branch_in  in  1 each  control bits from ID/EX
stall  in  1  hold EX/MEM contents
flush  in  1  insert bubble into EX/MEM
ex_mem_valid  out  1  registered valid
ex_mem_result  out  DATA_W  registered ALU result
ex_mem_zero  out  1  registered (result == 0)
ex_mem_ovf  out  1  registered signed overflow, ADD/SUB only
ex_mem_illegal  out  1  registered illegal alu_ctrl flag
ex_mem_store_data  out  DATA_W  forwarded operand B before the alu_src mux
ex_mem_rd  out  REG_AW  registered destination register
ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write, ex_mem_mem_to_reg, ex_mem_branch  out  1 each  registered control bits

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, including valid, all control bits and all data.
- Latency: combinational forwarding and ALU; results appear on outputs 1 clk edge after inputs are sampled.
- Operand A = fwd_a-selected value. Operand B = imm_ext when alu_src=1, otherwise the fwd_b-selected value. fwd code 11 aliases to EX/MEM, because EX/MEM is the most recent producer.
- ADD/SUB: two's-complement modulo 2^DATA_W.
  - ovf = operand signs equal (ADD), or operand signs differ (SUB), and result sign differs from operand A sign.
  - ovf = 0 for all other ops.
  - Overflow does not suppress reg_write.
- SLT: signed compare; result = {DATA_W-1 zeros, a<b}. Correct when a-b overflows, e.g. 0x80000000 < 0x7FFFFFFF gives 1.
- NOR: ~(a|b).
- Illegal alu_ctrl, including 1111:
  - result 0, illegal=1.
  - reg_write, mem_read and mem_write forced to 0 in the registered copy.
  - zero=1 follows from result 0.
- id_ex_valid=0: registered as a bubble; valid and all five control bits 0, data don't-care but driven as computed.
- Per-edge priority: flush > stall > normal load.
  - flush=1: bubble (valid and all control bits 0; data registers may load).
  - stall=1, flush=0: every output register holds its value.
  - stall and flush together: flush wins.
- Reset asserted mid-operation clears in-flight contents immediately. First load happens on the first edge after deassertion.

Decomposition:
- Shared package (pipeline_pkg): ALU control code constants (AND, OR, ADD, SUB, SLT, NOR, ILLEGAL=1111) and forwarding select constants (FWD_REG, FWD_EXMEM, FWD_MEMWB). The ALU control decoder imports the same constants.
- One sub-module, alu_core: combinational. Takes a, b and alu_ctrl; produces result, zero, ovf and illegal.
- ex_stage_alu_reg holds the forwarding muxes and the EX/MEM register.

Test Plan:
- Reset: drive rst_n low mid-stream with valid data in flight -> all outputs 0 without waiting for a clock edge.
- ADD overflow: alu_ctrl=0010, rs=0x7FFFFFFF, rt=1, fwd 00/00 -> next cycle result=0x80000000, ovf=1, zero=0, reg_write passes through.
- Signed SLT and SUB zero:
  - SLT (0111), a=0x80000000, b=0x7FFFFFFF -> result=1, ovf=0.
  - SUB (0110), a=b=5 -> result=0, zero=1.
- Forwarding: fwd_a=10, ex_mem_fwd=0x10, fwd_b=01, mem_wb_fwd=0x3, alu_src=0, AND (0000) -> result=0x0, store_data=0x3.
  - Repeat with fwd_a=11 -> A still uses 0x10.
  - alu_src=1, imm=0xFFFFFFFF, ADD -> result=0x0F, store_data=0x3.
- Stall/flush:
  - Load an instruction, then stall=1 for 3 cycles while inputs change -> outputs constant.
  - stall=1 with flush=1 -> next cycle valid=0 and all control bits 0.
- Illegal code: alu_ctrl=1111, reg_write_in=1, mem_write_in=1 -> illegal=1, result=0, zero=1, reg_write=0, mem_write=0, valid=1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: ALU control codes, forwarding selects and the
// control-bit bundle carried down the pipeline registers.
package pipeline_pkg;

   typedef enum logic [3:0] {
      ALU_AND     = 4'b0000,
      ALU_OR      = 4'b0001,
      ALU_ADD     = 4'b0010,
      ALU_SUB     = 4'b0110,
      ALU_SLT     = 4'b0111,
      ALU_NOR     = 4'b1100,
      ALU_ILLEGAL = 4'b1111
   } alu_op_e;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic branch;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/alu_core.sv
// Combinational MIPS ALU: result, zero, signed overflow (ADD/SUB only) and
// an illegal-code flag that forces the result to zero.
module alu_core
   import pipeline_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        alu_ctrl,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              ovf,
   output logic              illegal
);

   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] diff;
   logic              sa;
   logic              sb;

   assign sum  = a + b;
   assign diff = a - b;
   assign sa   = a[DATA_W-1];
   assign sb   = b[DATA_W-1];

   always_comb begin
      result  = '0;
      ovf     = 1'b0;
      illegal = 1'b0;
      case (alu_ctrl)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_NOR: result = ~(a | b);
         ALU_ADD: begin
            result = sum;
            ovf    = (sa == sb) && (sum[DATA_W-1] != sa);
         end
         ALU_SUB: begin
            result = diff;
            ovf    = (sa != sb) && (diff[DATA_W-1] != sa);
         end
         // Direct signed compare, so a wrapped a-b cannot flip the answer.
         ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         default: illegal = 1'b1;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/ex_stage_alu_reg.sv
// MIPS execute stage: operand forwarding, ALU, and the EX/MEM pipeline register
// with flush-over-stall handling.
module ex_stage_alu_reg
   import pipeline_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        alu_ctrl,
   input  logic              id_ex_valid,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic [DATA_W-1:0] imm_ext,
   input  logic              alu_src,
   input  logic [1:0]        fwd_a,
   input  logic [1:0]        fwd_b,
   input  logic [DATA_W-1:0] ex_mem_fwd,
   input  logic [DATA_W-1:0] mem_wb_fwd,
   input  logic [REG_AW-1:0] rd_in,
   input  logic              reg_write_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic              mem_to_reg_in,
   input  logic              branch_in,
   input  logic              stall,
   input  logic              flush,
   output logic              ex_mem_valid,
   output logic [DATA_W-1:0] ex_mem_result,
   output logic              ex_mem_zero,
   output logic              ex_mem_ovf,
   output logic              ex_mem_illegal,
   output logic [DATA_W-1:0] ex_mem_store_data,
   output logic [REG_AW-1:0] ex_mem_rd,
   output logic              ex_mem_reg_write,
   output logic              ex_mem_mem_read,
   output logic              ex_mem_mem_write,
   output logic              ex_mem_mem_to_reg,
   output logic              ex_mem_branch
);

   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] fwd_b_val;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;
   logic              alu_ovf;
   logic              alu_illegal;
   ctrl_t             ctrl_in;

   logic              valid_d,   valid_q;
   logic [DATA_W-1:0] result_d,  result_q;
   logic              zero_d,    zero_q;
   logic              ovf_d,     ovf_q;
   logic              illegal_d, illegal_q;
   logic [DATA_W-1:0] store_d,   store_q;
   logic [REG_AW-1:0] rd_d,      rd_q;
   ctrl_t             ctrl_d,    ctrl_q;

   // Code 11 aliases to EX/MEM: it is the most recent producer.
   always_comb begin
      op_a = ex_mem_fwd;
      case (fwd_a)
         FWD_REG:   op_a = rs_data;
         FWD_MEMWB: op_a = mem_wb_fwd;
         default:   op_a = ex_mem_fwd;
      endcase
   end

   always_comb begin
      fwd_b_val = ex_mem_fwd;
      case (fwd_b)
         FWD_REG:   fwd_b_val = rt_data;
         FWD_MEMWB: fwd_b_val = mem_wb_fwd;
         default:   fwd_b_val = ex_mem_fwd;
      endcase
   end

   assign op_b = alu_src ? imm_ext : fwd_b_val;

   alu_core #(.DATA_W(DATA_W)) u_alu (
      .a        (op_a),
      .b        (op_b),
      .alu_ctrl (alu_ctrl),
      .result   (alu_result),
      .zero     (alu_zero),
      .ovf      (alu_ovf),
      .illegal  (alu_illegal)
   );

   assign ctrl_in = '{reg_write:  reg_write_in,
                      mem_read:   mem_read_in,
                      mem_write:  mem_write_in,
                      mem_to_reg: mem_to_reg_in,
                      branch:     branch_in};

   always_comb begin
      valid_d   = valid_q;
      result_d  = result_q;
      zero_d    = zero_q;
      ovf_d     = ovf_q;
      illegal_d = illegal_q;
      store_d   = store_q;
      rd_d      = rd_q;
      ctrl_d    = ctrl_q;
      if (flush || !stall) begin
         result_d  = alu_result;
         zero_d    = alu_zero;
         ovf_d     = alu_ovf;
         illegal_d = alu_illegal;
         store_d   = fwd_b_val;
         rd_d      = rd_in;
         if (flush || !id_ex_valid) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NONE;
         end else begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_in;
            // An illegal op must not touch architectural state.
            if (alu_illegal) begin
               ctrl_d.reg_write = 1'b0;
               ctrl_d.mem_read  = 1'b0;
               ctrl_d.mem_write = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         ovf_q     <= 1'b0;
         illegal_q <= 1'b0;
         store_q   <= '0;
         rd_q      <= '0;
         ctrl_q    <= CTRL_NONE;
      end else begin
         valid_q   <= valid_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         ovf_q     <= ovf_d;
         illegal_q <= illegal_d;
         store_q   <= store_d;
         rd_q      <= rd_d;
         ctrl_q    <= ctrl_d;
      end
   end

   assign ex_mem_valid      = valid_q;
   assign ex_mem_result     = result_q;
   assign ex_mem_zero       = zero_q;
   assign ex_mem_ovf        = ovf_q;
   assign ex_mem_illegal    = illegal_q;
   assign ex_mem_store_data = store_q;
   assign ex_mem_rd         = rd_q;
   assign ex_mem_reg_write  = ctrl_q.reg_write;
   assign ex_mem_mem_read   = ctrl_q.mem_read;
   assign ex_mem_mem_write  = ctrl_q.mem_write;
   assign ex_mem_mem_to_reg = ctrl_q.mem_to_reg;
   assign ex_mem_branch     = ctrl_q.branch;

endmodule

// File: tb/tb_ex_stage_alu_reg.sv
// Directed bench for ex_stage_alu_reg: hand-computed vectors checked with
// immediate assertions one cycle after each load.
module tb_ex_stage_alu_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  alu_ctrl;
   logic        id_ex_valid;
   logic [31:0] rs_data, rt_data, imm_ext;
   logic        alu_src;
   logic [1:0]  fwd_a, fwd_b;
   logic [31:0] ex_mem_fwd, mem_wb_fwd;
   logic [4:0]  rd_in;
   logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, branch_in;
   logic        stall, flush;
   logic        ex_mem_valid;
   logic [31:0] ex_mem_result;
   logic        ex_mem_zero, ex_mem_ovf, ex_mem_illegal;
   logic [31:0] ex_mem_store_data;
   logic [4:0]  ex_mem_rd;
   logic        ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;
   logic        ex_mem_mem_to_reg, ex_mem_branch;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_stage_alu_reg #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .alu_ctrl(alu_ctrl), .id_ex_valid(id_ex_valid),
      .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext), .alu_src(alu_src),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_mem_fwd(ex_mem_fwd), .mem_wb_fwd(mem_wb_fwd),
      .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
      .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in), .branch_in(branch_in),
      .stall(stall), .flush(flush),
      .ex_mem_valid(ex_mem_valid), .ex_mem_result(ex_mem_result),
      .ex_mem_zero(ex_mem_zero), .ex_mem_ovf(ex_mem_ovf),
      .ex_mem_illegal(ex_mem_illegal), .ex_mem_store_data(ex_mem_store_data),
      .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
      .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
      .ex_mem_mem_to_reg(ex_mem_mem_to_reg), .ex_mem_branch(ex_mem_branch)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] ctrl_out();
      return {ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write,
              ex_mem_mem_to_reg, ex_mem_branch};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_ctrl = 4'b0010; id_ex_valid = 1'b1;
      rs_data = '0; rt_data = '0; imm_ext = '0; alu_src = 1'b0;
      fwd_a = 2'b00; fwd_b = 2'b00; ex_mem_fwd = '0; mem_wb_fwd = '0;
      rd_in = '0; reg_write_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
      mem_to_reg_in = 1'b0; branch_in = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      rs_data = 32'h1234; rt_data = 32'h1; reg_write_in = 1'b1; rd_in = 5'd3;
      step();
      step();
      chk("rst_valid", {31'd0, ex_mem_valid}, 32'd0);
      chk("rst_result", ex_mem_result, 32'd0);
      chk("rst_ctrl", {27'd0, ctrl_out()}, 32'd0);
      chk("rst_rd", {27'd0, ex_mem_rd}, 32'd0);

      // ADD overflow; reg_write still passes
      rst_n = 1'b1;
      idle(); alu_ctrl = 4'b0010; rs_data = 32'h7FFF_FFFF; rt_data = 32'h1;
      reg_write_in = 1'b1; rd_in = 5'd9;
      step();
      chk("add_result", ex_mem_result, 32'h8000_0000);
      chk("add_ovf", {31'd0, ex_mem_ovf}, 32'd1);
      chk("add_zero", {31'd0, ex_mem_zero}, 32'd0);
      chk("add_rw", {31'd0, ex_mem_reg_write}, 32'd1);
      chk("add_valid", {31'd0, ex_mem_valid}, 32'd1);
      chk("add_rd", {27'd0, ex_mem_rd}, 32'd9);

      // SUB overflow: most negative minus one
      idle(); alu_ctrl = 4'b0110; rs_data = 32'h8000_0000; rt_data = 32'h1;
      step();
      chk("subovf_result", ex_mem_result, 32'h7FFF_FFFF);
      chk("subovf_ovf", {31'd0, ex_mem_ovf}, 32'd1);

      idle(); alu_ctrl = 4'b0111; rs_data = 32'h8000_0000; rt_data = 32'h7FFF_FFFF;
      step();
      chk("slt_result", ex_mem_result, 32'd1);
      chk("slt_ovf", {31'd0, ex_mem_ovf}, 32'd0);

      idle(); alu_ctrl = 4'b0110; rs_data = 32'd5; rt_data = 32'd5;
      step();
      chk("sub_result", ex_mem_result, 32'd0);
      chk("sub_zero", {31'd0, ex_mem_zero}, 32'd1);
      chk("sub_ovf", {31'd0, ex_mem_ovf}, 32'd0);

      idle(); alu_ctrl = 4'b1100; rs_data = 32'h0F0F_0000; rt_data = 32'h00F0_000F;
      step();
      chk("nor_result", ex_mem_result, 32'hF000_FFF0);

      // Forwarding
      idle(); alu_ctrl = 4'b0000; fwd_a = 2'b10; fwd_b = 2'b01;
      rs_data = 32'h100; rt_data = 32'h55; ex_mem_fwd = 32'h10; mem_wb_fwd = 32'h3;
      step();
      chk("fwd_and_result", ex_mem_result, 32'h0);
      chk("fwd_and_store", ex_mem_store_data, 32'h3);
      fwd_a = 2'b11; alu_ctrl = 4'b0001;
      step();
      chk("fwd11_or_result", ex_mem_result, 32'h13);
      alu_ctrl = 4'b0000;
      step();
      chk("fwd11_and_result", ex_mem_result, 32'h0);
      fwd_a = 2'b10; alu_src = 1'b1; imm_ext = 32'hFFFF_FFFF; alu_ctrl = 4'b0010;
      step();
      chk("imm_add_result", ex_mem_result, 32'h0F);
      chk("imm_add_store", ex_mem_store_data, 32'h3);
      fwd_a = 2'b01; alu_src = 1'b0; fwd_b = 2'b00; alu_ctrl = 4'b0001;
      step();
      chk("fwd01_or_result", ex_mem_result, 32'h57);

      // Stall holds for three cycles while inputs change
      idle(); alu_ctrl = 4'b0010; rs_data = 32'd2; rt_data = 32'd3; rd_in = 5'd7;
      mem_read_in = 1'b1; reg_write_in = 1'b1;
      step();
      chk("pre_stall_result", ex_mem_result, 32'd5);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rs_data = 32'd100 + i; rd_in = 5'd20 + 5'(i); mem_read_in = 1'b0; reg_write_in = 1'b0;
         step();
         chk("stall_result", ex_mem_result, 32'd5);
         chk("stall_rd", {27'd0, ex_mem_rd}, 32'd7);
         chk("stall_ctrl", {27'd0, ctrl_out()}, 32'b11000);
         chk("stall_valid", {31'd0, ex_mem_valid}, 32'd1);
      end
      reg_write_in = 1'b1; mem_write_in = 1'b1; branch_in = 1'b1; flush = 1'b1;
      step();
      chk("flush_valid", {31'd0, ex_mem_valid}, 32'd0);
      chk("flush_ctrl", {27'd0, ctrl_out()}, 32'd0);

      // Illegal code
      idle(); alu_ctrl = 4'b1111; rs_data = 32'd9; rt_data = 32'd4;
      reg_write_in = 1'b1; mem_write_in = 1'b1; mem_read_in = 1'b1; branch_in = 1'b1;
      step();
      chk("ill_flag", {31'd0, ex_mem_illegal}, 32'd1);
      chk("ill_result", ex_mem_result, 32'd0);
      chk("ill_zero", {31'd0, ex_mem_zero}, 32'd1);
      chk("ill_ctrl", {27'd0, ctrl_out()}, 32'b00001);
      chk("ill_valid", {31'd0, ex_mem_valid}, 32'd1);
      alu_ctrl = 4'b0011;
      step();
      chk("ill0011_flag", {31'd0, ex_mem_illegal}, 32'd1);

      // Bubble from ID/EX
      idle(); id_ex_valid = 1'b0; alu_ctrl = 4'b0001; rs_data = 32'hA0; rt_data = 32'h0B;
      reg_write_in = 1'b1; mem_to_reg_in = 1'b1;
      step();
      chk("bubble_valid", {31'd0, ex_mem_valid}, 32'd0);
      chk("bubble_ctrl", {27'd0, ctrl_out()}, 32'd0);
      chk("bubble_result", ex_mem_result, 32'hAB);

      // Asynchronous reset mid-stream
      idle(); rs_data = 32'd40; rt_data = 32'd2; reg_write_in = 1'b1; rd_in = 5'd4;
      step();
      chk("pre_rst_result", ex_mem_result, 32'd42);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, ex_mem_valid}, 32'd0);
      chk("arst_result", ex_mem_result, 32'd0);
      chk("arst_ctrl", {27'd0, ctrl_out()}, 32'd0);
      chk("arst_rd", {27'd0, ex_mem_rd}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_rst_result", ex_mem_result, 32'd42);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
